keccak_absorb_ctrl: RTL and testbench
=====================================

# keccak_absorb_ctrl

Upstream framer for the Keccak byte-padding stage. Accepts a message of `msg_len` bytes as a stream of 64-bit words and emits one word per cycle toward the padder, together with per-lane controls: `sel_din`, `sel_pad_location`, `last_word`, `block_end`. It inserts pad-only words and whole pad-only blocks as required, so the padder plus state-XOR stage receives exactly `(floor(L/R)+1)*RW` words. Here `L` is the message length in bytes, `R` is the rate in bytes, and `RW = R/8`.

## Interface
- `W`, default 64: word width. Only 64 is supported.
- `LEN_W`, default 16: width of the message byte length.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  starts a message; honoured only in IDLE.
- `mode`  in  2  latched at `start`. Encodings:
  - 00 SHA3-256, R=136.
  - 01 SHA3-512, R=72.
  - 10 SHAKE128, R=168.
  - 11 SHAKE256, R=136.
- `msg_len`  in  LEN_W  message length `L` in bytes; latched at `start`.
- `in_valid`, `in_ready`  in/out  1  message-word handshake.
- `in_data`  in  W  message word. The first byte of the word is in bits 63:56; byte b of the word is in lane 7-b.
- `out_valid`, `out_ready`  out/in  1  output handshake.
- `out_data`  out  W  registered `in_data` for data words; zero for pad-only words.
- `sel_din`  out  W/8  lane carries message data.
- `sel_pad_location`  out  W/8  lane holds the first pad byte (0x06 or 0x1F).
- `last_word`  out  1  last word of the final rate block; the padder ORs 0x80 into lane 0.
- `block_end`  out  1  last word of any rate block; downstream starts a permutation.
- `mode_out`  out  2  latched mode, passed to the padder.
- `busy`  out  1  high from `start` until the final word is accepted.
- `done`  out  1  one-cycle pulse after the final word is accepted.

## Operation
- Definitions:
  - `k` = global output word index, starting at 0.
  - byte b of word k = message byte `8k+b`.
  - `sel_din[7-b] = (8k+b < L)`.
  - `sel_pad_location[7-b] = (8k+b == L)`.
  - `wib` = word index within the current block, 0..RW-1.
  - `block_end = (wib == RW-1)`.
  - `last_word = block_end && (pad byte already emitted or in this word)`.
- Counters:
  - `wib` wraps at RW-1.
  - `byte_cnt` (LEN_W+4 bits) = 8k, and is never allowed to wrap.
- FSM: IDLE, DATA, PAD.
  - IDLE: `in_ready`=0. On `start`: latch `mode` and `L`, clear counters, assert `busy`. Go to DATA if L>0, else PAD.
  - DATA: `in_ready = !out_valid || out_ready`. Each accepted input loads the output register with the controls above.
    - If that word held the last data byte (`8k+8 >= L`) and `last_word`=1, the message ends.
    - Else if that word held the last data byte, go to PAD.
    - Otherwise stay in DATA.
  - PAD: no input is consumed (`in_ready`=0). A zero word is emitted whenever the output register is free. Stay in PAD until a word with `last_word`=1 is loaded.
  - Message end: after the handshake of the word with `last_word`=1, pulse `done`, drop `busy`, return to IDLE.
- Boundary cases:
  - L%8 != 0: the pad byte shares the last data word.
  - L%8 == 0 (L>0): the pad byte is lane 7 of a pad-only word.
  - L == R-1: a single word has `sel_pad_location[0]`=1 and `last_word`=1; the padder produces 0x86 or 0x9F in lane 0.
  - L a multiple of R (including L=0): the last data word has `block_end`=1, `last_word`=0. A full pad block of RW words follows; its first word has the pad byte in lane 7.
  - `start` while `busy`: ignored.
  - `in_valid` in IDLE or PAD: ignored, since `in_ready`=0.
- `rst` at any time aborts the message; the next cycle is IDLE with all outputs at their reset values.

## Timing
- Reset values are 0 for all outputs: `in_ready`, `out_valid`, `out_data`, `sel_din`, `sel_pad_location`, `last_word`, `block_end`, `mode_out`, `busy`, `done`.
- Latency: an input accepted at edge t appears on the output after edge t (one register stage).
- Throughput: one word per cycle with `out_ready`=1, both for data words and for pad words.
- While `out_valid && !out_ready`, all outputs are held stable and `in_ready`=0.
- The first output is available the cycle after `start`:
  - PAD, with L=0;
  - DATA, on the first `in_valid` otherwise.
- `done` is high in the cycle after the final handshake. A new `start` is accepted in that same cycle.

## Test plan
- SHAKE128, L=0 -> 21 words, all data zero.
  - Word 0: `sel_pad_location`=0x80.
  - Word 20: `last_word`=1, `block_end`=1.
  - `done` follows.
- SHA3-256, L=5 -> 17 words.
  - Word 0: `sel_din`=0xF8, `sel_pad_location`=0x04.
  - Only word 16 has `last_word`=1.
  - Exactly 1 input word is consumed.
- SHAKE256, L=135 -> word 16 has `sel_din`=0xFE, `sel_pad_location`=0x01, `last_word`=1. 17 words total.
- SHA3-512, L=72 -> 18 words.
  - Word 8: `block_end`=1, `last_word`=0.
  - Word 9: `sel_din`=0x00, `sel_pad_location`=0x80.
  - Word 17: `last_word`=1.
- SHAKE128, L=16, random `out_ready` stalls -> outputs stable during stalls.
  - Word 2 has `sel_pad_location`=0x80.
  - Word order and count (21) unchanged.
- `rst` asserted mid-DATA -> next cycle all outputs 0.
  - A fresh `start` (SHA3-256, L=8) runs cleanly: word 1 `sel_pad_location`=0x80.

Source files
------------

// File: rtl/keccak_absorb_ctrl.sv
// keccak_absorb_ctrl: frames a byte message into 64-bit words for the Keccak
// padder. It inserts pad-only words and pad-only blocks so that exactly
// (floor(L/R)+1)*RW words leave toward the state-XOR stage.
module keccak_absorb_ctrl #(
   parameter int W     = 64,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [LEN_W-1:0] msg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [W/8-1:0]   sel_din,
   output logic [W/8-1:0]   sel_pad_location,
   output logic             last_word,
   output logic             block_end,
   output logic [1:0]       mode_out,
   output logic             busy,
   output logic             done
);
   localparam int NB = W / 8;
   localparam int CW = LEN_W + 4;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD} state_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [CW-1:0]    byte_cnt_q, byte_cnt_d;
   logic [4:0]       wib_q, wib_d;
   logic             pad_done_q, pad_done_d;  // pad byte already emitted
   logic             fin_q, fin_d;            // final word sits in output reg
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic [NB-1:0]    sel_din_q, sel_din_d;
   logic [NB-1:0]    sel_pad_q, sel_pad_d;
   logic             last_word_q, last_word_d;
   logic             block_end_q, block_end_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [4:0]       rw_m1;
   logic [CW-1:0]    len_ext;
   logic [NB-1:0]    din_c, pad_c;
   logic             be_c, lw_c, last_byte_c, load_ok, load;

   // Lane controls for the word at byte_cnt, FSM next state and output loads
   always_comb begin
      case (mode_q)
         2'b01:   rw_m1 = 5'd8;
         2'b10:   rw_m1 = 5'd20;
         default: rw_m1 = 5'd16;
      endcase
      len_ext = CW'(len_q);
      for (int b = 0; b < NB; b++) begin
         din_c[NB-1-b] = (byte_cnt_q + CW'(b)) <  len_ext;
         pad_c[NB-1-b] = (byte_cnt_q + CW'(b)) == len_ext;
      end
      be_c        = (wib_q == rw_m1);
      lw_c        = be_c && (pad_done_q || (|pad_c));
      last_byte_c = (byte_cnt_q + CW'(NB)) >= len_ext;
      load_ok     = !out_valid_q || out_ready;
      in_ready    = (state_q == S_DATA) && !fin_q && load_ok;

      state_d     = state_q;
      mode_d      = mode_q;
      len_d       = len_q;
      byte_cnt_d  = byte_cnt_q;
      wib_d       = wib_q;
      pad_done_d  = pad_done_q;
      fin_d       = fin_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      sel_din_d   = sel_din_q;
      sel_pad_d   = sel_pad_q;
      last_word_d = last_word_q;
      block_end_d = block_end_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      load        = 1'b0;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d     = mode;
               len_d      = msg_len;
               byte_cnt_d = '0;
               wib_d      = '0;
               pad_done_d = 1'b0;
               fin_d      = 1'b0;
               busy_d     = 1'b1;
               state_d    = (msg_len == '0) ? S_PAD : S_DATA;
            end
         end
         default: begin
            if (fin_q) begin
               if (out_valid_q && out_ready) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  fin_d   = 1'b0;
               end
            end else begin
               load = (state_q == S_DATA) ? (in_valid && load_ok) : load_ok;
            end
         end
      endcase

      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = (state_q == S_DATA) ? in_data : '0;
         sel_din_d   = din_c;
         sel_pad_d   = pad_c;
         last_word_d = lw_c;
         block_end_d = be_c;
         byte_cnt_d  = byte_cnt_q + CW'(NB);
         wib_d       = be_c ? 5'd0 : wib_q + 5'd1;
         pad_done_d  = pad_done_q | (|pad_c);
         if (lw_c)
            fin_d = 1'b1;
         else if (state_q == S_DATA && last_byte_c)
            state_d = S_PAD;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mode_q      <= '0;
         len_q       <= '0;
         byte_cnt_q  <= '0;
         wib_q       <= '0;
         pad_done_q  <= 1'b0;
         fin_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sel_din_q   <= '0;
         sel_pad_q   <= '0;
         last_word_q <= 1'b0;
         block_end_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         len_q       <= len_d;
         byte_cnt_q  <= byte_cnt_d;
         wib_q       <= wib_d;
         pad_done_q  <= pad_done_d;
         fin_q       <= fin_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sel_din_q   <= sel_din_d;
         sel_pad_q   <= sel_pad_d;
         last_word_q <= last_word_d;
         block_end_q <= block_end_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign out_valid        = out_valid_q;
   assign out_data         = out_data_q;
   assign sel_din          = sel_din_q;
   assign sel_pad_location = sel_pad_q;
   assign last_word        = last_word_q;
   assign block_end        = block_end_q;
   assign mode_out         = mode_q;
   assign busy             = busy_q;
   assign done             = done_q;
endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Scoreboard bench for keccak_absorb_ctrl: expected words are queued when a
// message is started and compared as the DUT hands each word out.
module tb_keccak_absorb_ctrl;
   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_ready, out_valid, out_ready;
   logic [1:0]  mode, mode_out;
   logic [15:0] msg_len;
   logic [63:0] in_data, out_data;
   logic [7:0]  sel_din, sel_pad_location;
   logic        last_word, block_end, busy, done;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  din;
      logic [7:0]  pad;
      logic        lw;
      logic        be;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   keccak_absorb_ctrl #(.W(64), .LEN_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .msg_len(msg_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sel_din(sel_din), .sel_pad_location(sel_pad_location),
      .last_word(last_word), .block_end(block_end), .mode_out(mode_out),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] word_of(input int k);
      return {32'hDEAD0000 ^ 32'(k), 32'(k) * 32'd7 + 32'h1234};
   endfunction

   function automatic int rate_of(input logic [1:0] m);
      case (m)
         2'b00:   return 136;
         2'b01:   return 72;
         2'b10:   return 168;
         default: return 136;
      endcase
   endfunction

   task automatic run_msg(input logic [1:0] m, input int len, input bit stall);
      int   r, rw, nw, nin, in_idx;
      bit   in_acc, fin, held, ok;
      exp_t e, snap;
      r = rate_of(m); rw = r / 8; nw = (len / r + 1) * rw; nin = (len + 7) / 8;
      in_idx = 0; in_acc = 0; fin = 0; held = 0; ok = 0; snap = '0;
      for (int k = 0; k < nw; k++) begin
         e.data = (8 * k < len) ? word_of(k) : 64'd0;
         for (int b = 0; b < 8; b++) begin
            e.din[7-b] = (8 * k + b < len);
            e.pad[7-b] = (8 * k + b == len);
         end
         e.be = (k % rw == rw - 1);
         e.lw = (k == nw - 1);
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b1; mode = m; msg_len = 16'(len);
      in_valid = 1'b1; in_data = word_of(0); out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         // spurious starts while busy must be ignored
         start = !fin && (cyc % 5 == 2);
         mode  = ~m;
         #1;
         if (held) begin
            chk("hold_data", out_data, snap.data);
            chk("hold_ctl", {out_valid, sel_din, sel_pad_location, last_word, block_end},
                {1'b1, snap.din, snap.pad, snap.lw, snap.be});
            held = 0;
         end
         if (fin) begin
            chk("done", {done, busy, out_valid}, 3'b100);
            chk("mode_out", mode_out, m);
            ok = 1;
            break;
         end
         chk("busy", busy, 1'b1);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("extra_word", 1, 0);
            else begin
               e = sb.pop_front();
               chk("data", out_data, e.data);
               chk("ctl", {sel_din, sel_pad_location, last_word, block_end},
                   {e.din, e.pad, e.lw, e.be});
               if (sb.size() == 0) fin = 1;
            end
         end else if (out_valid) begin
            held = 1;
            snap = {out_data, sel_din, sel_pad_location, last_word, block_end};
            chk("stall_in_ready", in_ready, 1'b0);
         end
         in_acc = in_valid && in_ready;
         @(negedge clk);
         if (in_acc) begin
            in_idx++;
            in_data = word_of(in_idx);
         end
      end
      start = 1'b0; in_valid = 1'b0;
      if (!ok) chk("timeout", 0, 1);
      chk("inputs_used", 64'(in_idx), 64'(nin));
      sb.delete();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'b00; msg_len = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_data", out_data, 64'd0);
      chk("rst_ctl", {in_ready, out_valid, sel_din, sel_pad_location, last_word,
          block_end, mode_out, busy, done}, 64'd0);
      rst = 1'b0;

      run_msg(2'b10, 0, 0);    // SHAKE128 L=0: full pad block
      run_msg(2'b00, 5, 0);    // SHA3-256 short message
      run_msg(2'b11, 135, 0);  // L = R-1: 0x9F in lane 0
      run_msg(2'b01, 72, 0);   // L = R: extra pad block
      run_msg(2'b10, 16, 1);   // stalls on out_ready
      run_msg(2'b01, 13, 1);

      // abort mid-DATA
      @(negedge clk);
      start = 1'b1; mode = 2'b11; msg_len = 16'd200;
      in_valid = 1'b1; in_data = word_of(0); out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("abort_data", out_data, 64'd0);
      chk("abort_ctl", {in_ready, out_valid, sel_din, sel_pad_location, last_word,
          block_end, mode_out, busy, done}, 64'd0);
      rst = 1'b0; in_valid = 1'b0;

      run_msg(2'b00, 8, 0);    // fresh run after abort

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
